dmem_handshake_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the core's load/store interface, built with a ready/valid handshake.

---
 rtl/dmem_handshake_responder_if.sv | 37 +++
 rtl/dmem_handshake_responder.sv | 112 +++++++++++
 tb/tb_dmem_handshake_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dmem_handshake_responder_if.sv
// Load/store handshake bus between the core (master) and the data-memory responder (slave).
// Request and response channels each use an independent ready/valid pair.
interface dmem_handshake_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );
endinterface

// File: rtl/dmem_handshake_responder.sv
// Single-outstanding data-memory responder with WAIT_CYCLES wait states before each array access.
// Optional macro DMEM_MISALIGN_ERR_EN: misaligned requests skip the array and return resp_err=1.
module dmem_handshake_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    dmem_handshake_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** ADDR_BITS;

`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MISALIGN_ERR = 1'b1;
`else
    localparam bit MISALIGN_ERR = 1'b0;
`endif

    state_t                 state_reg;
    logic [3:0]             cnt_reg;
    logic                   write_reg;
    logic [ADDR_BITS-1:0]   index_reg;
    logic [31:0]            wdata_reg;
    logic                   misalign_reg;
    logic                   resp_valid_reg;
    logic [31:0]            resp_rdata_reg;
    logic                   resp_err_reg;

    logic [31:0]            mem [DEPTH];

    logic                   access;
    logic                   commit;
    logic                   unused_addr_bits;

    // Address bits above the word index only alias; they are never decoded.
    generate
        if (ADDR_BITS < 30) begin : g_addr_upper
            assign unused_addr_bits = ^bus.req_addr[31:ADDR_BITS+2];
        end else begin : g_addr_full
            assign unused_addr_bits = 1'b0;
        end
    endgenerate

    assign access = (state_reg == BUSY) && (cnt_reg == 4'd0);
    // A store asserted together with reset on its access edge must not land in the array.
    assign commit = access && write_reg && !misalign_reg && !reset;

    assign bus.req_ready  = (state_reg == IDLE) && !reset;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_err   = resp_err_reg;

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[index_reg] <= wdata_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_reg    <= bus.req_write;
                        index_reg    <= bus.req_addr[ADDR_BITS+1:2];
                        wdata_reg    <= bus.req_wdata;
                        misalign_reg <= MISALIGN_ERR && (bus.req_addr[1:0] != 2'b00);
                        cnt_reg      <= 4'(WAIT_CYCLES);
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= misalign_reg;
                        if (misalign_reg) begin
                            resp_rdata_reg <= 32'd0;
                        end else if (write_reg) begin
                            resp_rdata_reg <= wdata_reg;
                        end else begin
                            resp_rdata_reg <= mem[index_reg];
                        end
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_handshake_responder.sv
// Directed bench for dmem_handshake_responder: reset, store/load, backpressure, wrap, reset mid-op, misalign.
// Compiles with or without DMEM_MISALIGN_ERR_EN; expectations follow the macro.
module tb_dmem_handshake_responder;
    localparam int WAIT = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dmem_handshake_responder_if bus();

    dmem_handshake_responder #(
        .ADDR_BITS   (10),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge; returns once the response handshake has completed.
    task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input int hold, output logic [31:0] rd, output logic er);
        int n;
        int lat;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_addr  = 32'h0000_03FC;
        bus.req_wdata = 32'h0BAD_F00D;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(WAIT + 1));
        rd = bus.resp_rdata;
        er = bus.resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_resp_rdata", bus.resp_rdata, rd);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("done_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("done_req_ready", 32'(bus.req_ready), 32'd1);
        $display("txn write=%0b addr=%h wdata=%h rdata=%h err=%0b lat=%0d", w, a, d, rd, er, lat);
    endtask

    task automatic run(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int hold, input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        transact(w, a, d, hold, rd, er);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
    endtask

    // Store whose BUSY phase is cut short by reset; rst_after = edges after accept before reset is raised.
    task automatic store_with_reset(input logic [31:0] a, input logic [31:0] d, input int rst_after);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < rst_after; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midop_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("midop_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("midop_no_late_resp", 32'(bus.resp_valid), 32'd0);
        $display("txn reset-interrupted store addr=%h wdata=%h reset_after=%0d", a, d, rst_after);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b0;
        reset          = 1'b1;

        // T1 reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        // T2 store/load, T3 backpressure on the load
        run("store_10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0);
        run("load_10",  1'b0, 32'h0000_0010, 32'h0,        5, 32'hDEAD_BEEF, 1'b0);

        // T4 aliasing modulo 1024 words, plus top word via a high address
        run("store_1004", 1'b1, 32'h0000_1004, 32'h1234_5678, 0, 32'h1234_5678, 1'b0);
        run("load_0004",  1'b0, 32'h0000_0004, 32'h0,         0, 32'h1234_5678, 1'b0);
        run("store_0ffc", 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0);
        run("load_fffc",  1'b0, 32'hFFFF_FFFC, 32'h0,         0, 32'hCAFE_F00D, 1'b0);
        run("load_10_again", 1'b0, 32'h0000_0010, 32'h0,      0, 32'hDEAD_BEEF, 1'b0);

        // T5 reset mid-operation: in BUSY with cnt=1, then exactly on the access edge
        run("clear_20", 1'b1, 32'h0000_0020, 32'h0, 0, 32'h0, 1'b0);
        store_with_reset(32'h0000_0020, 32'hAAAA_5555, 1);
        run("load_20_after_rst1", 1'b0, 32'h0000_0020, 32'h0, 0, 32'h0, 1'b0);
        store_with_reset(32'h0000_0020, 32'h5A5A_5A5A, 2);
        run("load_20_after_rst2", 1'b0, 32'h0000_0020, 32'h0, 0, 32'h0, 1'b0);

        // T6 misaligned store and load
`ifdef DMEM_MISALIGN_ERR_EN
        run("store_22", 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 0, 32'h0, 1'b1);
        run("load_20_after_mis", 1'b0, 32'h0000_0020, 32'h0, 0, 32'h0, 1'b0);
        run("load_23", 1'b0, 32'h0000_0023, 32'h0, 0, 32'h0, 1'b1);
`else
        run("store_22", 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1'b0);
        run("load_20_after_mis", 1'b0, 32'h0000_0020, 32'h0, 0, 32'hFFFF_FFFF, 1'b0);
        run("load_23", 1'b0, 32'h0000_0023, 32'h0, 0, 32'hFFFF_FFFF, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
